// File: rtl/grey_dec_counter.sv
// Multi-digit decimal counter, Johnson-coded digits.
// Up/down, sanitising load, wrap pulse, byte-wise snapshot readout.
module grey_dec_counter #(
    parameter int DIGITS = 12,
    parameter int SEL_W  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_en,
    input  logic                  i_dir,
    input  logic                  i_load,
    input  logic [5*DIGITS-1:0]   i_init,
    input  logic                  i_snap,
    input  logic [SEL_W-1:0]      i_sel,
    output logic [5*DIGITS-1:0]   o_digits,
    output logic [7:0]            o_cnt,
    output logic                  o_carry,
    output logic                  o_err,
    output logic                  o_snap_vld
);

    localparam int W = 5 * DIGITS;
    localparam int B = (W + 7) / 8;

    localparam logic [4:0] D_ZERO = 5'b00000;
    localparam logic [4:0] D_NINE = 5'b10000;

    logic [W-1:0]   digits_q;
    logic [W-1:0]   digits_d;
    logic [W-1:0]   load_val;
    logic           load_bad;
    logic           wrap;
    logic [W-1:0]   snap_q;
    logic [B*8-1:0] snap_vec;
    logic           carry_q;
    logic           err_q;
    logic           snap_vld_q;

    function automatic logic code_ok(input logic [4:0] d);
        case (d)
            5'b00000, 5'b00001, 5'b00011, 5'b00111, 5'b01111,
            5'b11111, 5'b11110, 5'b11100, 5'b11000, 5'b10000:
                code_ok = 1'b1;
            default:
                code_ok = 1'b0;
        endcase
    endfunction

    // Johnson step up: shift left, feed back inverted MSB.
    function automatic logic [4:0] step_up(input logic [4:0] d);
        step_up = {d[3:0], ~d[4]};
    endfunction

    // Johnson step down: shift right, feed back inverted LSB.
    function automatic logic [4:0] step_dn(input logic [4:0] d);
        step_dn = {~d[0], d[4:1]};
    endfunction

    // Parallel-load sanitiser: invalid digits become zero.
    always_comb begin
        load_val = '0;
        load_bad = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (code_ok(i_init[5*k +: 5])) begin
                load_val[5*k +: 5] = i_init[5*k +: 5];
            end else begin
                load_bad = 1'b1;
            end
        end
    end

    // Single-edge carry chain; wrap is the carry out of the top digit.
    always_comb begin
        logic       step;
        logic [4:0] cur;
        digits_d = digits_q;
        step     = i_en;
        for (int k = 0; k < DIGITS; k++) begin
            cur = digits_q[5*k +: 5];
            if (step) begin
                digits_d[5*k +: 5] = i_dir ? step_up(cur) : step_dn(cur);
            end
            step = step & (cur == (i_dir ? D_NINE : D_ZERO));
        end
        wrap = step;
        if (i_load) begin
            digits_d = load_val;
        end
    end

    // Counter, wrap pulse and error flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            digits_q <= '0;
            carry_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            digits_q <= digits_d;
            carry_q  <= ~i_load & wrap;
            if (i_load) begin
                err_q <= load_bad;
            end
        end
    end

    // Snapshot captures the pre-update count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            snap_q     <= '0;
            snap_vld_q <= 1'b0;
        end else if (i_snap) begin
            snap_q     <= digits_q;
            snap_vld_q <= 1'b1;
        end
    end

    assign snap_vec = (B*8)'(snap_q);

    // Byte mux; out-of-range selects read as zero.
    always_comb begin
        o_cnt = 8'h00;
        for (int b = 0; b < B; b++) begin
            if (i_sel == SEL_W'(b)) begin
                o_cnt = snap_vec[8*b +: 8];
            end
        end
    end

    assign o_digits   = digits_q;
    assign o_carry    = carry_q;
    assign o_err      = err_q;
    assign o_snap_vld = snap_vld_q;

endmodule

// File: tb/tb_grey_dec_counter.sv
// Directed bench for grey_dec_counter, DIGITS=3.
// Expected values are hand-computed Johnson encodings.
module tb_grey_dec_counter;

    localparam int DIGITS = 3;
    localparam int W      = 15;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic         dir;
    logic         load;
    logic [W-1:0] init;
    logic         snap;
    logic [7:0]   sel;
    logic [W-1:0] digits;
    logic [7:0]   cnt;
    logic         carry;
    logic         err;
    logic         snap_vld;

    int checks;
    int failures;

    grey_dec_counter #(
        .DIGITS (DIGITS),
        .SEL_W  (8)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_en       (en),
        .i_dir      (dir),
        .i_load     (load),
        .i_init     (init),
        .i_snap     (snap),
        .i_sel      (sel),
        .o_digits   (digits),
        .o_cnt      (cnt),
        .o_carry    (carry),
        .o_err      (err),
        .o_snap_vld (snap_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        en   = 1'b0;
        load = 1'b0;
        snap = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n = 1'b0;
        en    = 1'b0;
        dir   = 1'b1;
        load  = 1'b0;
        init  = '0;
        snap  = 1'b0;
        sel   = 8'd0;

        #12;
        check("rst_digits", 32'(digits), 32'h0);
        check("rst_cnt", 32'(cnt), 32'h0);
        check("rst_carry", 32'(carry), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_vld", 32'(snap_vld), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // load 123 and read back through the byte port
        load = 1'b1;
        init = 15'h0467;
        tick();
        idle();
        check("t1_digits", 32'(digits), 32'h0467);
        check("t1_vld_pre", 32'(snap_vld), 32'h0);
        snap = 1'b1;
        tick();
        idle();
        check("t1_vld", 32'(snap_vld), 32'h1);
        sel = 8'd0;
        #1 check("t1_sel0", 32'(cnt), 32'h67);
        sel = 8'd1;
        #1 check("t1_sel1", 32'(cnt), 32'h04);
        sel = 8'd2;
        #1 check("t1_sel2", 32'(cnt), 32'h00);
        sel = 8'd255;
        #1 check("t1_sel255", 32'(cnt), 32'h00);

        // up wrap from 999
        load = 1'b1;
        init = 15'h4210;
        tick();
        idle();
        check("t2_load", 32'(digits), 32'h4210);
        check("t2_carry_pre", 32'(carry), 32'h0);
        en  = 1'b1;
        dir = 1'b1;
        tick();
        check("t2_wrap", 32'(digits), 32'h0000);
        check("t2_carry", 32'(carry), 32'h1);
        tick();
        idle();
        check("t2_next", 32'(digits), 32'h0001);
        check("t2_carry_off", 32'(carry), 32'h0);

        // down wrap from reset
        #2 rst_n = 1'b0;
        #1 check("t3_rst", 32'(digits), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        en  = 1'b1;
        dir = 1'b0;
        tick();
        check("t3_wrap", 32'(digits), 32'h4210);
        check("t3_carry", 32'(carry), 32'h1);
        tick();
        idle();
        check("t3_next", 32'(digits), 32'h4218);
        check("t3_carry_off", 32'(carry), 32'h0);

        // invalid digit 0 is sanitised, valid load clears error
        load = 1'b1;
        init = 15'h7FE5;
        tick();
        check("t4_digits", 32'(digits), 32'h7FE0);
        check("t4_err", 32'(err), 32'h1);
        init = 15'h0467;
        tick();
        idle();
        check("t4_reload", 32'(digits), 32'h0467);
        check("t4_err_clr", 32'(err), 32'h0);

        // load + count + snap together at 123
        load = 1'b1;
        en   = 1'b1;
        dir  = 1'b1;
        snap = 1'b1;
        init = 15'h4210;
        tick();
        idle();
        check("t5_digits", 32'(digits), 32'h4210);
        check("t5_carry", 32'(carry), 32'h0);
        sel = 8'd0;
        #1 check("t5_sel0", 32'(cnt), 32'h67);
        sel = 8'd1;
        #1 check("t5_sel1", 32'(cnt), 32'h04);

        // snapshot on a wrapping edge keeps the terminal value
        en   = 1'b1;
        snap = 1'b1;
        tick();
        idle();
        check("t5w_digits", 32'(digits), 32'h0000);
        check("t5w_carry", 32'(carry), 32'h1);
        sel = 8'd0;
        #1 check("t5w_sel0", 32'(cnt), 32'h10);
        sel = 8'd1;
        #1 check("t5w_sel1", 32'(cnt), 32'h42);

        // hold
        tick();
        tick();
        check("hold_digits", 32'(digits), 32'h0000);
        check("hold_carry", 32'(carry), 32'h0);

        // set err, count, then reset mid-cycle
        load = 1'b1;
        init = 15'h0005;
        tick();
        idle();
        check("t6_load", 32'(digits), 32'h0000);
        check("t6_err", 32'(err), 32'h1);
        en  = 1'b1;
        dir = 1'b1;
        tick();
        tick();
        check("t6_count", 32'(digits), 32'h0003);
        sel = 8'd1;
        #2 rst_n = 1'b0;
        #1;
        check("t6_digits", 32'(digits), 32'h0);
        check("t6_cnt", 32'(cnt), 32'h0);
        check("t6_carry", 32'(carry), 32'h0);
        check("t6_err_rst", 32'(err), 32'h0);
        check("t6_vld", 32'(snap_vld), 32'h0);
        #3 rst_n = 1'b1;
        tick();
        check("t6_resume", 32'(digits), 32'h0001);
        tick();
        idle();
        check("t6_resume2", 32'(digits), 32'h0003);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
